vga_frame_gen: RTL and testbench
================================

Name: vga_frame_gen

Overview:
VGA timing and pixel-stream generator; the transmit end of the VGA_CLK/V_SYNC/pixel interface consumed by the camera averaging path. Produces H_SYNC/V_SYNC/BLANK_N and an 8-bit pixel per VGA_CLK from a programmable colour and pattern mode. Colour updates use a toggle handshake (upd/upd_ack) and take effect only at frame boundaries, so a frame is never torn. Used as a loopback stimulus source and as the display-side driver.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC_W, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC_W, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
VGA_CLK  in  1  pixel clock; all state on rising edge
RST_N  in  1  asynchronous active-low reset
color  in  8  requested base colour; captured on an upd toggle
mode  in  2  pattern select: 0 solid, 1 ramp, 2 checker, 3 treated as solid; sampled at frame start
upd  in  1  toggle request; any level change means "new colour on color"
upd_ack  out  1  toggles once when a pending colour becomes active
H_SYNC  out  1  horizontal sync, active low
V_SYNC  out  1  vertical sync, active low
BLANK_N  out  1  high during the active region
pixel  out  8  pixel value; 0 while BLANK_N=0
x  out  11  active column (0 while blanked)
y  out  10  active row (0 while blanked)
frame_start  out  1  one-cycle pulse coincident with the outputs for position (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC_W+H_BP; V_TOTAL likewise. Internal h_cnt runs 0..H_TOTAL-1 and wraps; v_cnt increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. H sync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC_W). V sync low for v_cnt in the analogous line range, for whole lines.
- All outputs are registered from the same counter state: one-cycle latency from counters, and mutually aligned.
- Reset (asynchronous): h_cnt=v_cnt=0; H_SYNC=V_SYNC=1; BLANK_N=0; pixel=0; x=y=0; frame_start=0; upd_ack=0; active and pending colour=0; pending flag=0; active mode=0; upd sample register=0.
- The first rising edge after RST_N deasserts presents position (0,0) on the outputs with frame_start=1.
- Handshake: upd is registered once (upd_q). When upd!=upd_q, color is captured into pending and the pending flag is set. A later toggle before the boundary overwrites pending (last wins). upd_ack toggles only once per applied update.
- Frame boundary is the cycle in which the counters wrap to (0,0):
  - If pending is set: active_color<=pending, flag cleared, upd_ack toggles.
  - active_mode<=mode, regardless of pending.
  - A toggle sampled in the boundary cycle itself goes to pending and applies at the next boundary.
- Pixel, active region:
  - mode 0 or 3: active_color.
  - mode 1: active_color + x[7:0], modulo 256.
  - mode 2: active_color if x[3]^y[3] = 0, else ~active_color.
- Reset asserted mid-frame: immediate return to reset values; no partial state is retained.

Test Plan:
Use small parameters: H_ACTIVE=8, H_FP=2, H_SYNC_W=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC_W=1, V_BP=1 (V_TOTAL=7). One frame = 98 clocks.
- Timing after reset: frame_start every 98 clocks. Per line, BLANK_N high for 8 clocks, then H_SYNC low for clocks 10-11 of the line. V_SYNC low for all of line 5. pixel=0 throughout (colour 0).
- Solid update: mode=0, color=0x5A, toggle upd mid-frame. Current frame stays 0x00. From the next frame_start, pixel=0x5A in the active region, and upd_ack toggles exactly once, on the frame_start cycle.
- Last-wins: two toggles in one frame, with color 0x10 then 0x20. The next frame is 0x20 and upd_ack toggles once.
- Boundary toggle: toggle upd in the wrap cycle. The change is not visible in the frame that starts; it appears one frame later.
- Ramp wrap: mode=1, colour 0xFC. The active line reads FC, FD, FE, FF, 00, 01, 02, 03.
- Checker plus reset: mode=2, colour 0x0F with H_ACTIVE raised to 16. x=0-7 gives 0x0F and x=8-15 gives 0xF0. Assert RST_N low mid-line: all outputs take reset values asynchronously, and colour returns to 0.

Source files
------------

// File: rtl/vga_frame_gen.sv
// VGA timing and pixel-stream generator.
// Colour/mode changes land only on frame boundaries.
module vga_frame_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC_W = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic [7:0]  color,
  input  logic [1:0]  mode,
  input  logic        upd,
  output logic        upd_ack,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        BLANK_N,
  output logic [7:0]  pixel,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC_W + V_BP;

  localparam logic [10:0] H_ACT =
    11'(H_ACTIVE);
  localparam logic [10:0] H_SS =
    11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE =
    11'(H_ACTIVE + H_FP + H_SYNC_W);
  localparam logic [10:0] H_LAST =
    11'(H_TOTAL - 1);

  localparam logic [9:0] V_ACT =
    10'(V_ACTIVE);
  localparam logic [9:0] V_SS =
    10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE =
    10'(V_ACTIVE + V_FP + V_SYNC_W);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);

  // raster counters
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_wrap, v_wrap, boundary;

  // colour handshake and frame-latched state
  logic        upd_q;
  logic        tog;
  logic        pend_q, pend_d;
  logic [7:0]  pend_col_q, pend_col_d;
  logic [7:0]  act_col_q, act_col_d;
  logic [1:0]  act_mode_q, act_mode_d;
  logic        apply_q, apply_d;
  logic        ack_q, ack_d;

  // decoded raster position
  logic        act;
  logic        hs_n, vs_n, fs;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic        is_ramp, is_chk;
  logic [7:0]  pat;
  logic [7:0]  pix_d;

  assign h_wrap   = (h_cnt_q == H_LAST);
  assign v_wrap   = (v_cnt_q == V_LAST);
  assign boundary = h_wrap & v_wrap;
  assign tog      = upd ^ upd_q;

  // next raster position
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
    end
  end

  // raster counter registers
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // pending capture and boundary hand-over
  always_comb begin
    pend_d     = pend_q;
    pend_col_d = pend_col_q;
    act_col_d  = act_col_q;
    act_mode_d = act_mode_q;
    apply_d    = 1'b0;
    if (boundary) begin
      act_mode_d = mode;
      apply_d    = pend_q;
      pend_d     = 1'b0;
      if (pend_q) begin
        act_col_d = pend_col_q;
      end
    end
    // a toggle in the wrap cycle waits a frame
    if (tog) begin
      pend_d     = 1'b1;
      pend_col_d = color;
    end
  end

  // ack toggles alongside the first pixel using it
  always_comb begin
    ack_d = ack_q ^ apply_q;
  end

  // handshake and frame-latched registers
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      upd_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_col_q <= '0;
      act_col_q  <= '0;
      act_mode_q <= '0;
      apply_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      upd_q      <= upd;
      pend_q     <= pend_d;
      pend_col_q <= pend_col_d;
      act_col_q  <= act_col_d;
      act_mode_q <= act_mode_d;
      apply_q    <= apply_d;
      ack_q      <= ack_d;
    end
  end

  // timing decode from current counters
  always_comb begin
    act  = (h_cnt_q < H_ACT) &&
           (v_cnt_q < V_ACT);
    hs_n = !((h_cnt_q >= H_SS) &&
             (h_cnt_q < H_SE));
    vs_n = !((v_cnt_q >= V_SS) &&
             (v_cnt_q < V_SE));
    fs   = (h_cnt_q == '0) &&
           (v_cnt_q == '0);
    x_d  = act ? h_cnt_q : '0;
    y_d  = act ? v_cnt_q : '0;
  end

  // pattern generator
  always_comb begin
    is_ramp = (act_mode_q == 2'd1);
    is_chk  = (act_mode_q == 2'd2);
    pat     = act_col_q;
    unique case (1'b1)
      is_ramp: pat = act_col_q + x_d[7:0];
      is_chk:  pat = (x_d[3] ^ y_d[3]) ?
                     ~act_col_q : act_col_q;
      default: pat = act_col_q;
    endcase
    pix_d = act ? pat : 8'h00;
  end

  // aligned output registers
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_SYNC      <= 1'b1;
      V_SYNC      <= 1'b1;
      BLANK_N     <= 1'b0;
      pixel       <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      H_SYNC      <= hs_n;
      V_SYNC      <= vs_n;
      BLANK_N     <= act;
      pixel       <= pix_d;
      x           <= x_d;
      y           <= y_d;
      frame_start <= fs;
    end
  end

  assign upd_ack = ack_q;

endmodule

// File: tb/tb_vga_frame_gen.sv
// Directed bench for vga_frame_gen.
// Expected raster vectors queued per step, popped on output.
module tb_vga_frame_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] color = 8'h00;
  logic [1:0] mode = 2'd0;
  logic       upd = 1'b0;

  logic        a_ack, a_hs, a_vs, a_bn, a_fs;
  logic [7:0]  a_px;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic        b_ack, b_hs, b_vs, b_bn, b_fs;
  logic [7:0]  b_px;
  logic [10:0] b_x;
  logic [9:0]  b_y;

  logic [33:0] obs_a, obs_b;
  logic [33:0] sb[$];
  int total = 0;
  int bad = 0;
  int n = 0;

  localparam logic [33:0] RST_V =
    {1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
     8'h00, 11'd0, 10'd0};

  always #5 clk = ~clk;

  vga_frame_gen #(
    .H_ACTIVE(8), .H_FP(2),
    .H_SYNC_W(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1),
    .V_SYNC_W(1), .V_BP(1)
  ) u_dut (
    .VGA_CLK(clk), .RST_N(rst_n),
    .color(color), .mode(mode), .upd(upd),
    .upd_ack(a_ack), .H_SYNC(a_hs),
    .V_SYNC(a_vs), .BLANK_N(a_bn),
    .pixel(a_px), .x(a_x), .y(a_y),
    .frame_start(a_fs)
  );

  vga_frame_gen #(
    .H_ACTIVE(16), .H_FP(2),
    .H_SYNC_W(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1),
    .V_SYNC_W(1), .V_BP(1)
  ) u_chk (
    .VGA_CLK(clk), .RST_N(rst_n),
    .color(color), .mode(mode), .upd(upd),
    .upd_ack(b_ack), .H_SYNC(b_hs),
    .V_SYNC(b_vs), .BLANK_N(b_bn),
    .pixel(b_px), .x(b_x), .y(b_y),
    .frame_start(b_fs)
  );

  assign obs_a = {a_hs, a_vs, a_bn, a_fs,
                  a_ack, a_px, a_x, a_y};
  assign obs_b = {b_hs, b_vs, b_bn, b_fs,
                  b_ack, b_px, b_x, b_y};

  // expected outputs for frame position p
  function automatic logic [33:0] mk(
    int p, int ha, logic [7:0] b,
    logic [1:0] md, logic ak);
    int ht, h, v;
    logic act, hs, vs, fs;
    logic [10:0] xx;
    logic [9:0]  yy;
    logic [7:0]  px;
    ht  = ha + 6;
    h   = p % ht;
    v   = (p / ht) % 7;
    act = (h < ha) && (v < 4);
    hs  = !((h >= ha + 2) && (h < ha + 4));
    vs  = (v != 5);
    fs  = (h == 0) && (v == 0);
    xx  = act ? 11'(h) : 11'd0;
    yy  = act ? 10'(v) : 10'd0;
    px  = 8'h00;
    if (act) begin
      if (md == 2'd1)
        px = b + xx[7:0];
      else if (md == 2'd2)
        px = (xx[3] ^ yy[3]) ? ~b : b;
      else
        px = b;
    end
    return {hs, vs, act, fs, ak, px, xx, yy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic compare(string tag,
                         logic [33:0] got);
    logic [33:0] e;
    e = sb.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s n=%0d got=%h exp=%h",
             tag, n, got, e);
    end
  endtask

  // push, clock, pop for cnt positions
  task automatic run(string tag, int cnt,
                     int ha, logic [7:0] b,
                     logic [1:0] md, logic ak);
    for (int i = 0; i < cnt; i++) begin
      sb.push_back(mk(n, ha, b, md, ak));
      tick();
      compare(tag, (ha == 8) ? obs_a : obs_b);
    end
  endtask

  task automatic reset_check(string tag);
    sb.push_back(RST_V);
    compare({tag, "_a"}, obs_a);
    sb.push_back(RST_V);
    compare({tag, "_b"}, obs_b);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    rst_n = 1'b1;
    n = 0;

    run("timing", 98, 8, 8'h00, 2'd0, 1'b0);

    run("pre_upd", 40, 8, 8'h00, 2'd0, 1'b0);
    color = 8'h5A;
    upd = 1'b1;
    run("no_tear", 58, 8, 8'h00, 2'd0, 1'b0);

    run("solid", 30, 8, 8'h5A, 2'd0, 1'b1);
    color = 8'h10;
    upd = 1'b0;
    run("solid", 20, 8, 8'h5A, 2'd0, 1'b1);
    color = 8'h20;
    upd = 1'b1;
    run("solid", 48, 8, 8'h5A, 2'd0, 1'b1);

    run("lastwin", 97, 8, 8'h20, 2'd0, 1'b0);
    color = 8'h77;
    upd = 1'b0;
    run("lastwin", 1, 8, 8'h20, 2'd0, 1'b0);

    run("bnd_hold", 98, 8, 8'h20, 2'd0, 1'b0);

    run("bnd_apply", 50, 8, 8'h77, 2'd0, 1'b1);
    mode = 2'd1;
    color = 8'hFC;
    upd = 1'b1;
    run("bnd_apply", 48, 8, 8'h77, 2'd0, 1'b1);

    run("ramp", 98, 8, 8'hFC, 2'd1, 1'b0);
    run("ramp_nxt", 3, 8, 8'hFC, 2'd1, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    reset_check("async_rst1");
    color = 8'h0F;
    mode = 2'd2;
    upd = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    run("chk_f0", 154, 16, 8'h00, 2'd0, 1'b0);
    run("checker", 33, 16, 8'h0F, 2'd2, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    reset_check("async_rst2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    run("post_rst", 154, 16, 8'h00, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
